iot_riscv_muldiv: RTL and testbench

IOT_RISCV_MULDIV -- requirements
Module: iot_riscv_muldiv

---
 rtl/iot_riscv_pkg.sv | 25 ++
 rtl/iot_riscv_muldiv_dp.sv | 47 ++++
 rtl/iot_riscv_muldiv.sv | 155 +++++++++++++++
 tb/tb_iot_riscv_muldiv.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/iot_riscv_pkg.sv
// Shared ALU op codes and mul/div FSM states for the iot_riscv core.
package iot_riscv_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [3:0] {
        ALU_MULL = 4'd9,
        ALU_MULH = 4'd10,
        ALU_DIV  = 4'd11,
        ALU_REM  = 4'd12
    } alu_op_e;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        CALC,
        FIX,
        DONE
    } md_state_e;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op >= 4'd9) && (op <= 4'd12);
    endfunction

endpackage

// File: rtl/iot_riscv_muldiv_dp.sv
// Iterative 64-bit datapath: radix-2 shift-add multiply, restoring divide.
module iot_riscv_muldiv_dp
    import iot_riscv_pkg::*;
(
    input  logic              clk,
    input  logic              rst_an,
    input  logic              load,
    input  logic              step,
    input  logic              is_div,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic [2*XLEN-1:0] acc
);

    logic [XLEN-1:0]   opnd;
    logic [XLEN:0]     sum;
    logic [XLEN:0]     part;
    logic [XLEN:0]     diff;
    logic              ge;
    logic [2*XLEN-1:0] acc_next;

    // Multiply: {hi, multiplier} shifts right, hi accumulates the multiplicand.
    // Divide: {rem, quotient} shifts left, quotient bits enter at bit 0.
    always_comb begin
        sum      = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        part     = acc[63:31];
        ge       = part >= {1'b0, opnd};
        diff     = part - {1'b0, opnd};
        acc_next = {sum, acc[31:1]};
        if (is_div) begin
            acc_next = {(ge ? diff[31:0] : part[31:0]), acc[30:0], ge};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_an) begin
            acc  <= '0;
            opnd <= '0;
        end else if (load) begin
            acc  <= is_div ? {32'd0, a} : {32'd0, b};
            opnd <= is_div ? b : a;
        end else if (step) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/iot_riscv_muldiv.sv
// Multi-cycle RV32M multiply/divide unit: FSM, sign handling, special cases.
module iot_riscv_muldiv
    import iot_riscv_pkg::*;
(
    input  logic        main_clk_i,
    input  logic        rst_an_i,
    input  logic        req_i,
    input  logic [3:0]  op_i,
    input  logic        a_signed_i,
    input  logic        b_signed_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        kill_i,
    output logic        ack_o,
    output logic        busy_o,
    output logic        valid_o,
    output logic [31:0] result_o
);

    md_state_e   state;
    logic [5:0]  cnt;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        a_sgn;
    logic        b_sgn;
    logic        neg_res;
    logic        neg_rem;
    logic [31:0] res;

    logic        accept;
    logic        is_div;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic        div0;
    logic        ovf;
    logic [63:0] acc;
    logic [63:0] prod;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] fix_res;
    logic [31:0] spec_res;

    assign accept = rst_an_i && (state == IDLE) && req_i && !kill_i
                    && is_muldiv(op_i);
    assign is_div = (op == ALU_DIV) || (op == ALU_REM);
    assign a_neg  = a_sgn && a[31];
    assign b_neg  = b_sgn && b[31];
    assign a_abs  = a_neg ? (~a + 32'd1) : a;
    assign b_abs  = b_neg ? (~b + 32'd1) : b;
    assign div0   = is_div && (b == 32'd0);
    assign ovf    = is_div && a_sgn && b_sgn
                    && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    assign prod = neg_res ? (~acc + 64'd1) : acc;
    assign quo  = neg_res ? (~acc[31:0] + 32'd1) : acc[31:0];
    assign rem  = neg_rem ? (~acc[63:32] + 32'd1) : acc[63:32];

    always_comb begin
        fix_res = rem;
        case (op)
            ALU_MULL: fix_res = prod[31:0];
            ALU_MULH: fix_res = prod[63:32];
            ALU_DIV:  fix_res = quo;
            default:  fix_res = rem;
        endcase
    end

    always_comb begin
        spec_res = 32'd0;
        if (div0) begin
            spec_res = (op == ALU_DIV) ? 32'hFFFF_FFFF : a;
        end else if (op == ALU_DIV) begin
            spec_res = 32'h8000_0000;
        end
    end

    iot_riscv_muldiv_dp u_dp (
        .clk    (main_clk_i),
        .rst_an (rst_an_i),
        .load   (state == PREP),
        .step   (state == CALC),
        .is_div (is_div),
        .a      (a_abs),
        .b      (b_abs),
        .acc    (acc)
    );

    always_ff @(posedge main_clk_i) begin
        if (!rst_an_i) begin
            state   <= IDLE;
            cnt     <= '0;
            op      <= '0;
            a       <= '0;
            b       <= '0;
            a_sgn   <= 1'b0;
            b_sgn   <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            res     <= '0;
        end else if (kill_i) begin
            state <= IDLE;
            cnt   <= '0;
            res   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op    <= op_i;
                        a     <= a_i;
                        b     <= b_i;
                        a_sgn <= a_signed_i;
                        b_sgn <= b_signed_i;
                        state <= PREP;
                    end
                end
                PREP: begin
                    neg_res <= a_neg ^ b_neg;
                    neg_rem <= a_neg;
                    cnt     <= '0;
                    if (div0 || ovf) begin
                        res   <= spec_res;
                        state <= DONE;
                    end else begin
                        state <= CALC;
                    end
                end
                CALC: begin
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    res   <= fix_res;
                    state <= DONE;
                end
                DONE: begin
                    res   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ack_o    = accept;
    assign busy_o   = rst_an_i && (accept || (state == PREP)
                      || (state == CALC) || (state == FIX));
    assign valid_o  = rst_an_i && !kill_i && (state == DONE);
    assign result_o = valid_o ? res : 32'd0;

endmodule

// File: tb/tb_iot_riscv_muldiv.sv
// Directed-vector bench for iot_riscv_muldiv.
module tb_iot_riscv_muldiv;

    logic        clk = 1'b0;
    logic        rst_an;
    logic        req;
    logic [3:0]  op;
    logic        a_sgn;
    logic        b_sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic        kill;
    logic        ack;
    logic        busy;
    logic        valid;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    iot_riscv_muldiv dut (
        .main_clk_i (clk),
        .rst_an_i   (rst_an),
        .req_i      (req),
        .op_i       (op),
        .a_signed_i (a_sgn),
        .b_signed_i (b_sgn),
        .a_i        (a),
        .b_i        (b),
        .kill_i     (kill),
        .ack_o      (ack),
        .busy_o     (busy),
        .valid_o    (valid),
        .result_o   (result)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] o, input logic s1, input logic s2,
                         input logic [31:0] x, input logic [31:0] y);
        req   = 1'b1;
        op    = o;
        a_sgn = s1;
        b_sgn = s2;
        a     = x;
        b     = y;
    endtask

    task automatic run_op(input string tag, input logic [3:0] o,
                          input logic s1, input logic s2,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp, input int lat);
        int n;
        drive(o, s1, s2, x, y);
        #1;
        chk({tag, " ack"}, 32'(ack), 32'd1);
        chk({tag, " busy"}, 32'(busy), 32'd1);
        tick();
        req = 1'b0;
        n = 1;
        while (!valid && n < 60) begin
            tick();
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'(lat));
        chk({tag, " result"}, result, exp);
        tick();
        chk({tag, " valid drop"}, 32'(valid), 32'd0);
        chk({tag, " result drop"}, result, 32'd0);
    endtask

    initial begin
        int seen;
        rst_an = 1'b0;
        req = 1'b0; op = 4'd0; a_sgn = 1'b0; b_sgn = 1'b0;
        a = 32'd0; b = 32'd0; kill = 1'b0;
        tick(); tick();
        drive(4'd9, 1'b1, 1'b1, 32'd7, 32'd3);
        #1;
        chk("rst ack", 32'(ack), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst valid", 32'(valid), 32'd0);
        chk("rst result", result, 32'd0);
        req = 1'b0;
        tick();
        rst_an = 1'b1;
        tick();

        drive(4'd3, 1'b0, 1'b0, 32'd1, 32'd1);
        #1;
        chk("bad op ack", 32'(ack), 32'd0);
        chk("bad op busy", 32'(busy), 32'd0);
        tick();
        req = 1'b0;
        chk("bad op idle", 32'(busy), 32'd0);

        run_op("mull", 4'd9, 1, 1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 35);
        run_op("mulhu", 4'd10, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 35);
        run_op("mulh", 4'd10, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'h0000_0000, 35);
        run_op("mulhsu", 4'd10, 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFF, 35);
        run_op("div s", 4'd11, 1, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35);
        run_op("rem s", 4'd12, 1, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35);
        run_op("divu", 4'd11, 0, 0, 32'd100, 32'd7, 32'd14, 35);
        run_op("remu", 4'd12, 0, 0, 32'd100, 32'd7, 32'd2, 35);
        run_op("div0", 4'd11, 1, 1, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
        run_op("remu0", 4'd12, 0, 0, 32'd5, 32'd0, 32'd5, 2);
        run_op("rem0 neg", 4'd12, 1, 1, 32'hFFFF_FFF9, 32'd0,
               32'hFFFF_FFF9, 2);
        run_op("div ovf", 4'd11, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h8000_0000, 2);
        run_op("rem ovf", 4'd12, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF,
               32'd0, 2);

        drive(4'd9, 0, 0, 32'd3, 32'd5);
        #1;
        chk("kill ack", 32'(ack), 32'd1);
        tick();
        req = 1'b0;
        for (int i = 2; i <= 10; i++) begin
            if (i == 5) begin
                drive(4'd9, 0, 0, 32'd1, 32'd1);
                #1;
                chk("busy req ignored", 32'(ack), 32'd0);
                chk("busy mid op", 32'(busy), 32'd1);
                req = 1'b0;
            end
            tick();
        end
        kill = 1'b1;
        #1;
        chk("kill valid", 32'(valid), 32'd0);
        tick();
        kill = 1'b0;
        chk("kill busy", 32'(busy), 32'd0);
        chk("kill no valid", 32'(valid), 32'd0);
        run_op("after kill", 4'd9, 0, 0, 32'd6, 32'd7, 32'd42, 35);

        drive(4'd11, 0, 0, 32'd1000, 32'd10);
        #1;
        chk("rst op ack", 32'(ack), 32'd1);
        tick();
        req = 1'b0;
        for (int i = 2; i <= 20; i++) tick();
        rst_an = 1'b0;
        tick();
        chk("mid rst ack", 32'(ack), 32'd0);
        chk("mid rst busy", 32'(busy), 32'd0);
        chk("mid rst valid", 32'(valid), 32'd0);
        chk("mid rst result", result, 32'd0);
        rst_an = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (valid || busy) seen++;
        end
        chk("mid rst discarded", 32'(seen), 32'd0);
        run_op("after rst", 4'd11, 0, 0, 32'd1000, 32'd10, 32'd100, 35);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
